sar_search: RTL and testbench

- Successive-approximation controller; the driving side of the team's magnitude comparator.
- Drives a trial operand into an external combinational comparator, with A = target and B = trial.
- Reads back the equal / A>B / A<B flags and converges on the unsigned target value in SIZE compare cycles, MSB first.
- Used for threshold search, ADC-style SAR loops and comparator bring-up.

---
 rtl/sar_search_if.sv | 26 ++
 rtl/sar_search.sv | 124 ++++++++++++
 tb/tb_sar_search.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/sar_search_if.sv
// Bus between the SAR controller and the external comparator / requester.
// master: the sar_search controller. slave: the comparator + requester side.
interface sar_search_if #(
    parameter int SIZE = 4
);
    logic            start;
    logic            cmp_eq;
    logic            cmp_gt;
    logic            cmp_lt;
    logic [SIZE-1:0] trial;
    logic            busy;
    logic            done;
    logic [SIZE-1:0] result;
    logic            err;
    logic [1:0]      state_dbg;

    modport master (
        input  start, cmp_eq, cmp_gt, cmp_lt,
        output trial, busy, done, result, err, state_dbg
    );

    modport slave (
        output start, cmp_eq, cmp_gt, cmp_lt,
        input  trial, busy, done, result, err, state_dbg
    );
endinterface

// File: rtl/sar_search.sv
// Successive-approximation search controller.
// Drives a trial operand to an external combinational comparator (A = target,
// B = trial) and resolves the unsigned target MSB first in SIZE compare cycles.
// Optional macro SAR_SEARCH_EARLY_EXIT_EN: a valid one-hot cmp_eq ends the
// search immediately with the current trial as result.
//
// Handshake: start is a single-cycle request honoured only in IDLE (no
// queueing, ignored while busy or done). Completion is signalled by a
// one-cycle done pulse; result stays valid until the next accepted start.
module sar_search #(
    parameter int SIZE = 4
) (
    input  logic          clk,
    input  logic          rst,
    sar_search_if.master  bus
);
    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(SIZE - 1);
    localparam logic [SIZE-1:0]  TOP_BIT = {1'b1, {(SIZE-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SIZE-1:0]   trial_q, trial_d;
    logic [SIZE-1:0]   result_q, result_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              err_q, err_d;
    logic [SIZE-1:0]   trial_upd;
    logic [IDX_W-1:0]  idx_m1;
    logic              flags_onehot;

    // Comparator flags are valid only when exactly one is asserted
    always_comb begin
        flags_onehot = ({bus.cmp_eq, bus.cmp_gt, bus.cmp_lt} == 3'b001) ||
                       ({bus.cmp_eq, bus.cmp_gt, bus.cmp_lt} == 3'b010) ||
                       ({bus.cmp_eq, bus.cmp_gt, bus.cmp_lt} == 3'b100);
    end

    // State and datapath registers; rst overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            trial_q  <= '0;
            result_q <= '0;
            idx_q    <= IDX_TOP;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            trial_q  <= trial_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
        end
    end

    // Next-state and bit-decision logic
    always_comb begin
        state_d   = state_q;
        trial_d   = trial_q;
        result_d  = result_q;
        idx_d     = idx_q;
        err_d     = err_q;
        trial_upd = trial_q;
        idx_m1    = idx_q - IDX_W'(1);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SEARCH;
                    trial_d = TOP_BIT;
                    idx_d   = IDX_TOP;
                    err_d   = 1'b0;
                end
            end

            SEARCH: begin
                if (!flags_onehot) begin
                    err_d = 1'b1;
                end
                // Only cmp_lt drives the decision; eq and gt both keep the bit
                if (bus.cmp_lt) begin
                    trial_upd[idx_q] = 1'b0;
                end
`ifdef SAR_SEARCH_EARLY_EXIT_EN
                if (bus.cmp_eq && flags_onehot) begin
                    result_d = trial_q;
                    state_d  = DONE;
                end else
`endif
                if (idx_q == '0) begin
                    trial_d  = trial_upd;
                    result_d = trial_upd;
                    state_d  = DONE;
                end else begin
                    trial_upd[idx_m1] = 1'b1;
                    trial_d           = trial_upd;
                    idx_d             = idx_m1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode straight from registered state
    always_comb begin
        bus.trial     = trial_q;
        bus.result    = result_q;
        bus.err       = err_q;
        bus.busy      = (state_q == SEARCH);
        bus.done      = (state_q == DONE);
        bus.state_dbg = state_q;
    end
endmodule

// File: tb/tb_sar_search.sv
// Directed testbench for sar_search (SIZE=4) with a behavioural comparator
// driven from a target value.
module tb_sar_search;
    localparam int SIZE = 4;

    logic clk;
    logic rst;
    logic [SIZE-1:0] target;
    logic force_zero;
    int checks;
    int errors;

    sar_search_if #(.SIZE(SIZE)) bus ();

    sar_search #(.SIZE(SIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Comparator model: A = target, B = trial; force_zero drops all flags
    assign bus.cmp_eq = !force_zero && (target == bus.trial);
    assign bus.cmp_gt = !force_zero && (target >  bus.trial);
    assign bus.cmp_lt = !force_zero && (target <  bus.trial);

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Full-length search: tr[3] is the cycle-1 trial, tr[0] the cycle-4 trial
    task automatic run_full(input string tag, input logic [SIZE-1:0] t,
                            input logic [3:0][SIZE-1:0] tr, input logic [SIZE-1:0] res);
        target    = t;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            check({tag, "_trial"}, bus.trial, tr[i]);
            check({tag, "_busy"},  bus.busy, 1);
            check({tag, "_done0"}, bus.done, 0);
            tick();
        end
        check({tag, "_done"},   bus.done, 1);
        check({tag, "_busyd"},  bus.busy, 0);
        check({tag, "_result"}, bus.result, res);
        check({tag, "_err"},    bus.err, 0);
        tick();
        check({tag, "_done_gone"}, bus.done, 0);
        check({tag, "_idle"},      bus.state_dbg, 0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        bus.start  = 1'b1;   // start held during reset must be ignored
        target     = '0;
        force_zero = 1'b0;
        tick();
        tick();
        tick();
        rst       = 1'b0;
        bus.start = 1'b0;
        check("rst_trial",  bus.trial, 0);
        check("rst_busy",   bus.busy, 0);
        check("rst_done",   bus.done, 0);
        check("rst_result", bus.result, 0);
        check("rst_err",    bus.err, 0);
        check("rst_state",  bus.state_dbg, 0);
        tick();

        run_full("t11", 4'd11, {4'd8, 4'd12, 4'd10, 4'd11}, 4'd11);
        run_full("t0",  4'd0,  {4'd8, 4'd4,  4'd2,  4'd1},  4'd0);
        run_full("t15", 4'd15, {4'd8, 4'd12, 4'd14, 4'd15}, 4'd15);

`ifdef SAR_SEARCH_EARLY_EXIT_EN
        // T=8: first trial is equal, search ends at once
        target    = 4'd8;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("t8e_trial", bus.trial, 8);
        check("t8e_busy",  bus.busy, 1);
        tick();
        check("t8e_done",   bus.done, 1);
        check("t8e_result", bus.result, 8);
        check("t8e_busyd",  bus.busy, 0);
        tick();
        check("t8e_done_gone", bus.done, 0);
        check("t8e_idle",      bus.state_dbg, 0);
`else
        run_full("t8", 4'd8, {4'd8, 4'd12, 4'd10, 4'd9}, 4'd8);
`endif

        // Invalid flags in cycle 2 set sticky err
        target    = 4'd5;
        bus.start = 1'b1;
        tick();                                   // cycle 1
        bus.start = 1'b0;
        check("err_c1_trial", bus.trial, 8);
        check("err_c1_err",   bus.err, 0);
        tick();                                   // cycle 2
        check("err_c2_trial", bus.trial, 4);
        force_zero = 1'b1;
        tick();                                   // cycle 3
        force_zero = 1'b0;
        check("err_c3_err",   bus.err, 1);
        check("err_c3_trial", bus.trial, 6);
        tick();                                   // cycle 4
        check("err_c4_trial", bus.trial, 5);
        tick();                                   // cycle 5
        check("err_c5_done",   bus.done, 1);
        check("err_c5_result", bus.result, 5);
        check("err_c5_err",    bus.err, 1);
        tick();                                   // cycle 6
        check("err_c6_err",  bus.err, 1);
        check("err_c6_done", bus.done, 0);
        bus.start = 1'b1;
        tick();                                   // cycle 7: new search
        bus.start = 1'b0;
        check("err_clr",       bus.err, 0);
        check("err_clr_busy",  bus.busy, 1);
        check("err_clr_trial", bus.trial, 8);
        tick();
        tick();
        tick();
        tick();                                   // cycle 11
        check("err2_done",   bus.done, 1);
        check("err2_result", bus.result, 5);
        check("err2_err",    bus.err, 0);
        tick();

        // Reset mid-search aborts
        target    = 4'd11;
        bus.start = 1'b1;
        tick();                                   // cycle 1
        bus.start = 1'b0;
        check("abort_c1_trial", bus.trial, 8);
        tick();                                   // cycle 2
        rst = 1'b1;
        tick();                                   // cycle 3
        rst = 1'b0;
        check("abort_busy",   bus.busy, 0);
        check("abort_trial",  bus.trial, 0);
        check("abort_result", bus.result, 0);
        check("abort_done",   bus.done, 0);
        check("abort_err",    bus.err, 0);
        check("abort_state",  bus.state_dbg, 0);
        tick();                                   // cycle 4
        bus.start = 1'b1;
        tick();                                   // cycle 5
        bus.start = 1'b0;
        check("rest_c5_trial", bus.trial, 8);
        check("rest_c5_busy",  bus.busy, 1);
        tick();
        tick();
        tick();
        tick();                                   // cycle 9
        check("rest_done",   bus.done, 1);
        check("rest_result", bus.result, 11);
        tick();

        // start pulses while busy / done are ignored (T=6)
        target    = 4'd6;
        bus.start = 1'b1;
        tick();                                   // cycle 1
        bus.start = 1'b0;
        check("ign_c1_trial", bus.trial, 8);
        tick();                                   // cycle 2
        check("ign_c2_trial", bus.trial, 4);
        bus.start = 1'b1;
        tick();                                   // cycle 3
        bus.start = 1'b0;
        check("ign_c3_trial", bus.trial, 6);
        check("ign_c3_busy",  bus.busy, 1);
`ifdef SAR_SEARCH_EARLY_EXIT_EN
        tick();                                   // cycle 4: eq seen in cycle 3
        check("ign_done",   bus.done, 1);
        check("ign_result", bus.result, 6);
        bus.start = 1'b1;
        tick();                                   // cycle 5
        bus.start = 1'b0;
`else
        tick();                                   // cycle 4
        check("ign_c4_trial", bus.trial, 7);
        tick();                                   // cycle 5
        check("ign_done",   bus.done, 1);
        check("ign_result", bus.result, 6);
        bus.start = 1'b1;
        tick();                                   // cycle 6
        bus.start = 1'b0;
`endif
        check("ign_after_busy",   bus.busy, 0);
        check("ign_after_done",   bus.done, 0);
        check("ign_after_state",  bus.state_dbg, 0);
        check("ign_after_result", bus.result, 6);
        tick();
        check("ign_still_idle", bus.busy, 0);
        check("ign_no_done",    bus.done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
